// File: rtl/onehot_encoder_seq.sv
// ---------------------------------------------------------------------------
// onehot_encoder_seq
//   Sequential encoder that serialises a multi-hot request vector into a
//   stream of binary indices, one per output handshake. It is the inverse of
//   the Decoder: feeding out_index_o to a Decoder reconstructs the one-hot of
//   the bit currently being reported.
//
//   Default ordering is lowest set bit first. Defining the macro
//   ONEHOT_ENCODER_MSB_FIRST_EN selects highest set bit first instead. In that
//   build out_last_o marks the lowest set bit. Handshake, latency and reset
//   behaviour are the same in both builds.
//
// Parameters
//   INPUT_WIDTH   index width in bits; the vector is 2**INPUT_WIDTH bits wide
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   in_vec_i       request vector to encode
//   in_valid_i     in_vec_i is valid
//   in_ready_o     block can accept a vector (high only in IDLE)
//   out_index_o    binary index of the current set bit
//   out_valid_o    out_index_o is valid (high only in EMIT)
//   out_ready_i    consumer accepts out_index_o
//   out_last_o     current index is the final set bit of the vector
//   empty_pulse_o  one-cycle pulse after an all-zero vector is accepted
// ---------------------------------------------------------------------------
module onehot_encoder_seq #(
  parameter int INPUT_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2**INPUT_WIDTH-1:0] in_vec_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [INPUT_WIDTH-1:0]    out_index_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o,
  output logic                      empty_pulse_o
);

  localparam int VEC_W = 2**INPUT_WIDTH;
  localparam logic [VEC_W-1:0] VEC_ONE = {{(VEC_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [VEC_W-1:0]       pending_q, pending_d;
  logic                   empty_q, empty_d;

  logic [INPUT_WIDTH-1:0] index_s;
  logic                   single_s;
  logic                   out_hs_s;

  // Priority encoder over the pending vector. The scan direction selects
  // which set bit is reported first; a zero vector encodes as index 0.
  function automatic logic [INPUT_WIDTH-1:0] prio_enc(input logic [VEC_W-1:0] v);
    logic [INPUT_WIDTH-1:0] idx;
    logic                   found;
    idx   = {INPUT_WIDTH{1'b0}};
    found = 1'b0;
`ifdef ONEHOT_ENCODER_MSB_FIRST_EN
    for (int i = VEC_W - 1; i >= 0; i--) begin
`else
    for (int i = 0; i < VEC_W; i++) begin
`endif
      if (v[i] && !found) begin
        idx   = i[INPUT_WIDTH-1:0];
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
    return idx;
  endfunction

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic is_single(input logic [VEC_W-1:0] v);
    return (v != {VEC_W{1'b0}}) && ((v & (v - VEC_ONE)) == {VEC_W{1'b0}});
  endfunction

  assign index_s  = prio_enc(pending_q);
  assign single_s = is_single(pending_q);

  // pending_q is all-zero whenever the FSM is in IDLE, so index and last
  // already read as zero there without extra gating on the state.
  assign in_ready_o    = (state_q == ST_IDLE);
  assign out_valid_o   = (state_q == ST_EMIT);
  assign out_index_o   = index_s;
  assign out_last_o    = single_s;
  assign empty_pulse_o = empty_q;
  assign out_hs_s      = out_valid_o && out_ready_i;

  // Next-state logic: accept a vector in IDLE, retire one bit per handshake in EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    empty_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          if (in_vec_i == {VEC_W{1'b0}}) begin
            // Nothing to emit; just flag it for one cycle.
            empty_d = 1'b1;
          end else begin
            pending_d = in_vec_i;
            state_d   = ST_EMIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_hs_s) begin
          pending_d = pending_q & ~(VEC_ONE << index_s);
          if (single_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          // Hold: pending only changes on a handshake.
          pending_d = pending_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = {VEC_W{1'b0}};
      end
    endcase
  end

  // State, pending vector and empty pulse registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= {VEC_W{1'b0}};
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      empty_q   <= empty_d;
    end
  end

endmodule

// File: doc/onehot_encoder_seq.md
Name: onehot_encoder_seq

Overview:
- Sequential encoder; performs the inverse of the Decoder.
- Accepts a 2**INPUT_WIDTH-bit request vector over a valid/ready handshake.
- Emits the binary index of every set bit, one index per output handshake, lowest index first by default.
- Used wherever a multi-hot vector (interrupt lines, register write masks) must be serialised into Decoder-compatible indices.

Parameters:
- INPUT_WIDTH, 5, index width in bits; vector width is 2**INPUT_WIDTH (default 32).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_vec  input  2**INPUT_WIDTH  request vector to encode
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- out_index  output  INPUT_WIDTH  binary index of the current set bit
- out_valid  output  1  out_index is valid
- out_ready  input  1  consumer accepts out_index
- out_last  output  1  current index is the final set bit of the vector
- empty_pulse  output  1  one-cycle pulse when an all-zero vector is accepted

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, pending register = 0, in_ready = 1, out_valid = 0, out_last = 0, empty_pulse = 0, out_index = 0.
- States: IDLE, EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready with in_vec != 0: pending <= in_vec; go to EMIT.
  - On in_valid && in_ready with in_vec == 0: stay in IDLE; empty_pulse = 1 on the following cycle only; no output handshake.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - out_index = priority encode of pending (lowest set bit), combinational from the pending register.
  - out_last = 1 when pending has exactly one bit set.
- Handshake on out_valid && out_ready:
  - Clear bit out_index in pending.
  - If out_last was 1, go to IDLE.
  - Otherwise stay in EMIT; the next index appears on the next cycle.
- Latency: a vector accepted at cycle N gives its first out_valid at N+1. With out_ready held high, K set bits take K cycles; in_ready returns high at N+K+1. There is no same-cycle overlap of the last output and a new input.
- Hold rules:
  - out_index and out_last are stable while out_valid = 1 and out_ready = 0.
  - pending is never modified without a handshake.
- in_vec is ignored in EMIT, and ignored in IDLE when in_valid = 0.
- Full vector (all ones): emits 0..2**INPUT_WIDTH-1 in order; out_last is set on index 2**INPUT_WIDTH-1.
- Single bit at the MSB: one output, index 2**INPUT_WIDTH-1, out_last = 1.
- Reset mid-EMIT: the pending vector is discarded, outputs return to reset values on the next cycle, and nothing further is emitted.
- Width rule: out_index is always exactly INPUT_WIDTH bits. Feeding out_index to the Decoder reconstructs the one-hot of the current bit.

Optional Feature:
- Macro: ONEHOT_ENCODER_MSB_FIRST_EN.
- Defined: priority encoding selects the highest set bit. Indices are emitted in descending order, and out_last marks the lowest set bit.
- Undefined: lowest-set-bit-first ordering, as described above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Reset then idle → in_ready = 1, out_valid = 0, out_index = 0, empty_pulse = 0.
- in_vec = 32'h0000_0029, out_ready = 1 → out_index 0, 3, 5 on consecutive cycles; out_last only with 5; in_ready high one cycle after.
- in_vec = 32'h8000_0001, out_ready low 3 cycles then high → out_index holds 0 with out_valid = 1 for 3 cycles, then 0, 31; out_last on 31.
- in_vec = 0 accepted → empty_pulse high exactly one cycle, out_valid never asserted, in_ready stays 1.
- in_vec = 32'hFFFF_FFFF, rst asserted after 4 handshakes → indices 0..3 emitted; the cycle after rst shows out_valid = 0, in_ready = 1; a new vector 32'h0000_0100 yields single index 8 with out_last = 1.
- With ONEHOT_ENCODER_MSB_FIRST_EN defined, in_vec = 32'h0000_0029 → out_index 5, 3, 0; out_last on 0. For every emitted index, Decoder(out_index) ANDed with the original vector is nonzero.
